// File: rtl/snn_pkg.sv
// Shared types for the SNN spike-bank scheduling blocks.
package snn_pkg;

  typedef enum logic {
    P_IDLE  = 1'b0,
    P_WRITE = 1'b1
  } prod_state_t;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_BUSY    = 2'd1,
    C_RELEASE = 2'd2
  } cons_state_t;

  localparam int unsigned PERF_CNT_W = 32;

  // Saturating increment for the optional performance counters
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bank_ring_ptr.sv
// Ring pointer over NUM_BANKS banks; wraps by explicit compare so that
// non-power-of-2 bank counts sequence correctly.
module bank_ring_ptr
  import snn_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [BANK_W-1:0] ptr
);

  localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS - 1);

  // Advance on inc, wrapping from the last bank back to bank 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spk_bank_sched.sv
// Spike-train RAM bank scheduler between two SNN layers.
// Grants write banks to the producer, hands filled banks to the fc
// event-control consumer, and tracks ring occupancy. No spike data passes
// through this block.
// Optional: define SPK_BANK_PERF_EN to add prod_stall_cyc / cons_idle_cyc.
module spk_bank_sched
  import snn_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_W      = ($clog2(NUM_BANKS) > 0) ? $clog2(NUM_BANKS) : 1,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prod_req,
  output logic                   prod_grant,
  output logic [BANK_W-1:0]      prod_bank,
  input  logic                   prod_done,
  output logic                   cons_start,
  output logic [BANK_W-1:0]      cons_bank,
  input  logic                   cons_done,
  output logic                   cons_rst,
  output logic                   full,
  output logic                   empty,
  output logic [BANK_W:0]        occupancy,
  output logic [FRAME_CNT_W-1:0] frames_done
`ifdef SPK_BANK_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  prod_stall_cyc,
  output logic [PERF_CNT_W-1:0]  cons_idle_cyc
`endif
);

  localparam logic [BANK_W:0] OCC_FULL = (BANK_W + 1)'(NUM_BANKS);

  prod_state_t       p_state, p_next;
  cons_state_t       c_state, c_next;
  logic [BANK_W-1:0] wr_ptr, rd_ptr;
  logic [BANK_W-1:0] cons_bank_q;
  logic [BANK_W:0]   occ_q;
  logic              cons_done_q;
  logic              wr_adv, rd_adv;
  logic              cons_done_rise;

  assign occupancy      = occ_q;
  assign full           = (occ_q == OCC_FULL);
  assign empty          = (occ_q == '0);
  assign prod_bank      = wr_ptr;
  assign cons_bank      = cons_bank_q;
  assign cons_done_rise = cons_done && !cons_done_q;

  bank_ring_ptr #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_adv),
    .ptr (wr_ptr)
  );

  bank_ring_ptr #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_adv),
    .ptr (rd_ptr)
  );

  // Producer state register
  always_ff @(posedge clk) begin
    if (rst) p_state <= P_IDLE;
    else     p_state <= p_next;
  end

  // Producer next state: grant only when a free bank exists
  always_comb begin
    p_next = p_state;
    unique case (p_state)
      P_IDLE:  if (prod_req && !full) p_next = P_WRITE;
      P_WRITE: if (prod_done)         p_next = P_IDLE;
      default: p_next = P_IDLE;
    endcase
  end

  // Producer outputs; prod_done is only honoured while writing
  always_comb begin
    prod_grant = 1'b0;
    wr_adv     = 1'b0;
    if (p_state == P_WRITE) begin
      prod_grant = 1'b1;
      wr_adv     = prod_done;
    end
  end

  // Consumer state register
  always_ff @(posedge clk) begin
    if (rst) c_state <= C_IDLE;
    else     c_state <= c_next;
  end

  // Consumer next state: release only on a fresh rising edge of cons_done
  always_comb begin
    c_next = c_state;
    unique case (c_state)
      C_IDLE:    if (!empty)         c_next = C_BUSY;
      C_BUSY:    if (cons_done_rise) c_next = C_RELEASE;
      C_RELEASE: c_next = C_IDLE;
      default:   c_next = C_IDLE;
    endcase
  end

  // Consumer outputs
  always_comb begin
    cons_start = 1'b0;
    cons_rst   = 1'b0;
    rd_adv     = 1'b0;
    unique case (c_state)
      C_BUSY:    cons_start = 1'b1;
      C_RELEASE: begin
        cons_rst = 1'b1;
        rd_adv   = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch the bank handed to the consumer and track cons_done history
  always_ff @(posedge clk) begin
    if (rst) begin
      cons_bank_q <= '0;
      cons_done_q <= 1'b0;
    end else begin
      cons_done_q <= cons_done;
      if (c_state == C_IDLE && !empty) cons_bank_q <= rd_ptr;
    end
  end

  // Occupancy and completed-frame count; a coincident fill and release cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      frames_done <= '0;
    end else begin
      unique case ({wr_adv, rd_adv})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: ;
      endcase
      if (rd_adv) frames_done <= frames_done + 1'b1;
    end
  end

`ifdef SPK_BANK_PERF_EN
  // Stall and idle cycle counters, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_stall_cyc <= '0;
      cons_idle_cyc  <= '0;
    end else begin
      if (p_state == P_IDLE && prod_req && full) prod_stall_cyc <= sat_inc(prod_stall_cyc);
      if (c_state == C_IDLE && empty)            cons_idle_cyc  <= sat_inc(cons_idle_cyc);
    end
  end
`endif

  property p_no_shared_bank;
    @(posedge clk) disable iff (rst)
      (prod_grant && cons_start) |-> (prod_bank != cons_bank);
  endproperty
  a_no_shared_bank: assert property (p_no_shared_bank);

endmodule
